// File: rtl/counter_sequencer.sv
// Run-control sequencer for a two-digit hex counter: prescaled up/down stepping
// to a latched limit, plus a time-multiplexed active-low seven-segment driver.
module counter_sequencer #(
  parameter int PRESCALE = 4,
  parameter int SCAN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clr,
  input  logic       dir,
  input  logic [7:0] limit,
  output logic [7:0] count,
  output logic       busy,
  output logic       done,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = (SCAN > 1) ? $clog2(SCAN) : 1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state, nstate;
  logic [7:0]    ncount, limreg, nlimreg, stepval;
  logic [PW-1:0] presc, npresc;
  logic [SW-1:0] scan, nscan;
  logic [1:0]    nan;

  function automatic logic [6:0] hexseg(input logic [3:0] d);
    case (d)
      4'h0: hexseg = 7'b1000000;
      4'h1: hexseg = 7'b1111001;
      4'h2: hexseg = 7'b0100100;
      4'h3: hexseg = 7'b0110000;
      4'h4: hexseg = 7'b0011001;
      4'h5: hexseg = 7'b0010010;
      4'h6: hexseg = 7'b0000010;
      4'h7: hexseg = 7'b1111000;
      4'h8: hexseg = 7'b0000000;
      4'h9: hexseg = 7'b0010000;
      4'hA: hexseg = 7'b0001000;
      4'hB: hexseg = 7'b0000011;
      4'hC: hexseg = 7'b1000110;
      4'hD: hexseg = 7'b0100001;
      4'hE: hexseg = 7'b0000110;
      default: hexseg = 7'b0001110;
    endcase
  endfunction

  // Run control: clr dominates, then stop, then start, then the prescaled step.
  always_comb begin
    nstate  = state;
    ncount  = count;
    nlimreg = limreg;
    npresc  = presc;
    stepval = dir ? (count + 8'd1) : (count - 8'd1);
    if (clr) begin
      nstate = IDLE;
      ncount = 8'h00;
      npresc = '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            nlimreg = limit;
            npresc  = '0;
            nstate  = RUN;
          end
        end
        PAUSE: begin
          if (start) begin
            nlimreg = limit;
            nstate  = RUN;
          end
        end
        default: begin
          if (stop) begin
            nstate = PAUSE;
          end else if (presc == PW'(PRESCALE - 1)) begin
            npresc = '0;
            ncount = stepval;
            if (stepval == limreg) nstate = DONE;
          end else begin
            npresc = presc + PW'(1);
          end
        end
      endcase
    end
  end

  // Free-running digit scan, independent of clr.
  always_comb begin
    nscan = scan + SW'(1);
    nan   = an;
    if (scan == SW'(SCAN - 1)) begin
      nscan = '0;
      nan   = ~an;
    end
  end

  // seg is registered from the next-state count and digit so it never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= 8'h00;
      limreg <= 8'h00;
      presc  <= '0;
      scan   <= '0;
      an     <= 2'b10;
      seg    <= 7'b1000000;
    end else begin
      state  <= nstate;
      count  <= ncount;
      limreg <= nlimreg;
      presc  <= npresc;
      scan   <= nscan;
      an     <= nan;
      seg    <= hexseg(nan[0] ? ncount[7:4] : ncount[3:0]);
    end
  end

  assign busy = (state == RUN) || (state == PAUSE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: a cycle model pushes expected outputs
// per edge, which are popped and compared against the DUT half a cycle later.
module tb_counter_sequencer;

  localparam int PRESCALE = 4;
  localparam int SCAN     = 8;
  localparam int MIDLE = 0, MRUN = 1, MPAUSE = 2, MDONE = 3;

  logic       clk, rst, start, stop, clr, dir;
  logic [7:0] limit, count;
  logic       busy, done;
  logic [6:0] seg;
  logic [1:0] an;

  typedef struct {
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic [1:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t sb[$];

  int assertCount = 0;
  int failCount   = 0;

  int         mState;
  logic [7:0] mCount, mLim, heldCount;
  int         mPre, mScan;
  logic       mSel;

  logic [6:0] segTable [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  counter_sequencer #(.PRESCALE(PRESCALE), .SCAN(SCAN)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr), .dir(dir),
    .limit(limit), .count(count), .busy(busy), .done(done), .seg(seg), .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    assertCount++;
    if (obs !== expv) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic modelReset();
    mState = MIDLE; mCount = 8'h00; mLim = 8'h00; mPre = 0; mScan = 0; mSel = 1'b0;
  endtask

  // Behavioural reference for one rising edge, using the inputs held across it.
  task automatic modelStep(input logic s, input logic p, input logic c, input logic d, input logic [7:0] l);
    exp_t e;
    if (c) begin
      mCount = 8'h00; mState = MIDLE; mPre = 0;
    end else if (mState == MRUN && p) begin
      mState = MPAUSE;
    end else if (mState != MRUN && s) begin
      mLim = l;
      if (mState != MPAUSE) mPre = 0;
      mState = MRUN;
    end else if (mState == MRUN) begin
      if (mPre == PRESCALE - 1) begin
        mPre = 0;
        mCount = d ? mCount + 8'd1 : mCount - 8'd1;
        if (mCount == mLim) mState = MDONE;
      end else begin
        mPre++;
      end
    end
    mScan++;
    if (mScan == SCAN) begin
      mScan = 0;
      mSel = ~mSel;
    end
    e.count = mCount;
    e.busy  = (mState == MRUN) || (mState == MPAUSE);
    e.done  = (mState == MDONE);
    e.an    = mSel ? 2'b01 : 2'b10;
    e.seg   = segTable[mSel ? mCount[7:4] : mCount[3:0]];
    sb.push_back(e);
  endtask

  task automatic drainScoreboard();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("count", {8'h00, count}, {8'h00, e.count});
      checkOutput("busy", {15'h0, busy}, {15'h0, e.busy});
      checkOutput("done", {15'h0, done}, {15'h0, e.done});
      checkOutput("an", {14'h0, an}, {14'h0, e.an});
      checkOutput("seg", {9'h0, seg}, {9'h0, e.seg});
    end
  endtask

  // Called at a falling edge; drives inputs, models the next rising edge, checks.
  task automatic applyStimulus(input logic s, input logic p, input logic c, input logic d, input logic [7:0] l);
    start = s; stop = p; clr = c; dir = d; limit = l;
    @(posedge clk);
    modelStep(s, p, c, d, l);
    @(negedge clk);
    drainScoreboard();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "Count"}, {8'h00, count}, 16'h0000);
    checkOutput({tag, "Busy"}, {15'h0, busy}, 16'h0000);
    checkOutput({tag, "Done"}, {15'h0, done}, 16'h0000);
    checkOutput({tag, "An"}, {14'h0, an}, 16'h0002);
    checkOutput({tag, "Seg"}, {9'h0, seg}, 16'h0040);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; clr = 1'b0; dir = 1'b1; limit = 8'h00;
    modelReset();
    #2;
    checkResetValues("rst");
    @(negedge clk);
    rst = 1'b0;

    // Up count to 3, then hold in DONE.
    applyStimulus(1, 0, 0, 1, 8'h03);
    for (int i = 0; i < 31; i++) applyStimulus(0, 0, 0, 1, 8'h03);
    checkOutput("upHold", {8'h00, count}, 16'h0003);
    checkOutput("upDone", {15'h0, done}, 16'h0001);

    // Down count through the 00 -> FF wrap.
    applyStimulus(0, 0, 1, 0, 8'hFE);
    applyStimulus(1, 0, 0, 0, 8'hFE);
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 0, 8'hFE);
    checkOutput("downWrap", {8'h00, count}, 16'h00FE);

    // Pause on a step-due edge, resume two cycles later.
    applyStimulus(0, 0, 1, 1, 8'h50);
    applyStimulus(1, 0, 0, 1, 8'h50);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 8'h50);
    for (int i = 0; i < 8 && mPre != PRESCALE - 1; i++) applyStimulus(0, 0, 0, 1, 8'h50);
    heldCount = mCount;
    applyStimulus(0, 1, 0, 1, 8'h50);
    checkOutput("pauseHold", {8'h00, count}, {8'h00, heldCount});
    checkOutput("pauseBusy", {15'h0, busy}, 16'h0001);
    applyStimulus(0, 0, 0, 1, 8'h50);
    applyStimulus(0, 0, 0, 1, 8'h50);
    checkOutput("pauseStill", {8'h00, count}, {8'h00, heldCount});
    applyStimulus(1, 0, 0, 1, 8'h50);
    checkOutput("resumeEdge", {8'h00, count}, {8'h00, heldCount});
    applyStimulus(0, 0, 0, 1, 8'h50);
    checkOutput("resumeStep", {8'h00, count}, {8'h00, heldCount + 8'd1});

    // Clear beats start and stop together.
    for (int i = 0; i < 200 && mCount != 8'h17; i++) applyStimulus(0, 0, 0, 1, 8'h50);
    checkOutput("reach17", {8'h00, count}, 16'h0017);
    applyStimulus(1, 1, 1, 1, 8'h50);
    checkOutput("clrCount", {8'h00, count}, 16'h0000);
    checkOutput("clrBusy", {15'h0, busy}, 16'h0000);
    checkOutput("clrDone", {15'h0, done}, 16'h0000);

    // Display scan with 3A held.
    applyStimulus(1, 0, 0, 1, 8'h3A);
    for (int i = 0; i < 300 && mState != MDONE; i++) applyStimulus(0, 0, 0, 1, 8'h3A);
    checkOutput("reach3A", {8'h00, count}, 16'h003A);
    for (int i = 0; i < 40; i++) applyStimulus(0, 0, 0, 1, 8'h3A);

    // Randomised control traffic.
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 255)));

    // Asynchronous reset mid-run at 42.
    applyStimulus(0, 0, 1, 1, 8'h80);
    applyStimulus(1, 0, 0, 1, 8'h80);
    for (int i = 0; i < 400 && mCount != 8'h42; i++) applyStimulus(0, 0, 0, 1, 8'h80);
    checkOutput("reach42", {8'h00, count}, 16'h0042);
    #1 rst = 1'b1;
    #1 checkResetValues("asyncRst");
    #1 rst = 1'b0;
    modelReset();
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 1, 8'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
